// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with FWFT/standard read mode, runtime thresholds and sticky error flags
//
// Ports:
//   clk, resetn       clock (rising edge), asynchronous active-low reset
//   clr               synchronous flush of pointers, count, flags and rd_valid
//   wr_en, wr_data    write request and word
//   rd_en             read request (pops the head in FWFT mode)
//   rd_data, rd_valid read word and its qualifier
//   full, empty       decoded from the registered count
//   af_th, ae_th      runtime almost-full / almost-empty thresholds
//   almost_full       count >= af_th
//   almost_empty      count <= ae_th
//   count             number of stored words
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
module sync_fifo_flex #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int FWFT        = 1,
  localparam int AW = (DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH,
  localparam int DW = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  input  logic [AW:0]   af_th,
  input  logic [AW:0]   ae_th,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          we;
  logic          re;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

  // A flush cycle ignores both requests.
  assign we = wr_en & ~full & ~clr;
  assign re = rd_en & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (re) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({we, re})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is read combinationally from storage, so a word written
      // into an empty FIFO is visible the cycle after its write edge.
      // Output is forced to zero while empty so reset shows rd_data = 0.
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else if (clr) begin
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= re;
          if (re) begin
            rd_data <= mem[rd_ptr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench for sync_fifo_flex in FWFT and standard read modes
module tb_sync_fifo_flex;

  logic       clk;
  logic       resetn;

  logic       a_clr, a_wr_en, a_rd_en;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [2:0] a_af_th, a_ae_th, a_count;

  logic       b_clr, b_wr_en, b_rd_en;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_af_th, b_ae_th, b_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  sync_fifo_flex #(.DEPTH_WIDTH(2), .DATA_WIDTH(8), .FWFT(1)) dut_a (
    .clk(clk), .resetn(resetn), .clr(a_clr), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .af_th(a_af_th), .ae_th(a_ae_th), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_flex #(.DEPTH_WIDTH(2), .DATA_WIDTH(8), .FWFT(0)) dut_b (
    .clk(clk), .resetn(resetn), .clr(b_clr), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .af_th(b_af_th), .ae_th(b_ae_th), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // FWFT monitor: a word is consumed when rd_en meets rd_valid at the next edge.
  always @(negedge clk) begin
    if (resetn && !a_clr && a_rd_en && a_rd_valid) begin
      n_checks++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_pop: got 0x%0h expected <no word>", a_rd_data);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (a_rd_data !== e) begin
          n_fail++;
          $display("FAIL a_pop: got 0x%0h expected 0x%0h", a_rd_data, e);
        end
      end
    end
  end

  // Standard-mode monitor: every rd_valid cycle delivers one word.
  always @(negedge clk) begin
    if (resetn && b_rd_valid) begin
      n_checks++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_pop: got 0x%0h expected <no word>", b_rd_data);
      end else begin
        logic [7:0] e;
        e = exp_b.pop_front();
        if (b_rd_data !== e) begin
          n_fail++;
          $display("FAIL b_pop: got 0x%0h expected 0x%0h", b_rd_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ae_tab;
    logic [3:0] af_tab;
    ae_tab = 4'b0001;
    af_tab = 4'b1100;

    resetn = 1'b0;
    a_clr = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = 0; a_af_th = 3'd3; a_ae_th = 3'd1;
    b_clr = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = 0; b_af_th = 3'd4; b_ae_th = 3'd0;
    #2;
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_rd_data", a_rd_data, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_unf", a_unf, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);
    check("rst_b_rd_data", b_rd_data, 0);
    a_af_th = 3'd0;
    #1;
    check("rst_af_th0", a_af, 1);
    a_af_th = 3'd3;
    #10;
    resetn = 1'b1;
    cyc();

    // single write, one-cycle latency
    a_wr_en = 1; a_wr_data = 8'h11; exp_a.push_back(8'h11);
    cyc();
    a_wr_en = 0;
    check("w1_empty", a_empty, 0);
    check("w1_rd_valid", a_rd_valid, 1);
    check("w1_rd_data", a_rd_data, 8'h11);
    check("w1_count", a_count, 1);
    a_rd_en = 1;
    cyc();
    a_rd_en = 0;
    check("r1_empty", a_empty, 1);
    check("r1_rd_valid", a_rd_valid, 0);

    // underflow then flush
    a_rd_en = 1;
    cyc();
    a_rd_en = 0;
    check("unf_set", a_unf, 1);
    check("unf_count", a_count, 0);
    a_clr = 1;
    cyc();
    a_clr = 0;
    check("clr_unf", a_unf, 0);

    // fill with thresholds
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'hA0 + i); exp_a.push_back(8'(8'hA0 + i));
      cyc();
      check("fill_count", a_count, i + 1);
      check("fill_ae", a_ae, ae_tab[i]);
      check("fill_af", a_af, af_tab[i]);
    end
    a_wr_en = 0;
    check("fill_full", a_full, 1);
    a_af_th = 3'd5;
    #1;
    check("af_th5", a_af, 0);
    a_af_th = 3'd3;
    #1;
    check("af_th3", a_af, 1);

    // overflow
    a_wr_en = 1; a_wr_data = 8'hEE;
    cyc();
    a_wr_en = 0;
    check("ovf_set", a_ovf, 1);
    check("ovf_count", a_count, 4);

    // simultaneous read/write from full across wrap
    a_wr_en = 1; a_rd_en = 1;
    for (int i = 0; i < 10; i++) begin
      a_wr_data = 8'(8'hB0 + i);
      if (i > 0) exp_a.push_back(8'(8'hB0 + i));
      cyc();
      check("rw_count", a_count, 3);
    end
    a_wr_en = 0;
    for (int i = 0; i < 3; i++) cyc();
    a_rd_en = 0;
    check("drain_empty", a_empty, 1);
    check("drain_count", a_count, 0);

    // clr with pending write while count=3 and overflow set
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'hC0 + i); exp_a.push_back(8'(8'hC0 + i));
      cyc();
    end
    a_wr_data = 8'hEE;
    cyc();
    a_wr_en = 0; a_rd_en = 1;
    cyc();
    a_rd_en = 0;
    check("pre_clr_count", a_count, 3);
    check("pre_clr_ovf", a_ovf, 1);
    a_clr = 1; a_wr_en = 1; a_wr_data = 8'hDD;
    cyc();
    a_clr = 0; a_wr_en = 0;
    exp_a.delete();
    check("clr_count", a_count, 0);
    check("clr_empty", a_empty, 1);
    check("clr_ovf", a_ovf, 0);
    check("clr_rd_valid", a_rd_valid, 0);

    // asynchronous reset mid-burst
    a_rd_en = 1;
    cyc();
    a_rd_en = 0;
    check("unf2_set", a_unf, 1);
    a_wr_en = 1; a_wr_data = 8'hE0; exp_a.push_back(8'hE0);
    cyc();
    a_wr_data = 8'hE1; exp_a.push_back(8'hE1);
    cyc();
    a_wr_data = 8'hE2;
    #2;
    resetn = 1'b0;
    #1;
    a_wr_en = 0;
    exp_a.delete();
    check("arst_count", a_count, 0);
    check("arst_empty", a_empty, 1);
    check("arst_full", a_full, 0);
    check("arst_rd_valid", a_rd_valid, 0);
    check("arst_rd_data", a_rd_data, 0);
    check("arst_ovf", a_ovf, 0);
    check("arst_unf", a_unf, 0);
    check("arst_ae", a_ae, 1);
    check("arst_af", a_af, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    a_wr_en = 1; a_wr_data = 8'hF0; exp_a.push_back(8'hF0);
    cyc();
    a_wr_en = 0;
    check("post_rst_data", a_rd_data, 8'hF0);
    check("post_rst_count", a_count, 1);
    a_rd_en = 1;
    cyc();
    a_rd_en = 0;
    check("post_rst_empty", a_empty, 1);

    // standard read mode
    b_wr_en = 1; b_wr_data = 8'h51; exp_b.push_back(8'h51);
    cyc();
    b_wr_data = 8'h52; exp_b.push_back(8'h52);
    cyc();
    b_wr_en = 0;
    check("b_idle_valid", b_rd_valid, 0);
    check("b_count", b_count, 2);
    b_rd_en = 1;
    cyc();
    b_rd_en = 0;
    check("b_r1_valid", b_rd_valid, 1);
    check("b_r1_data", b_rd_data, 8'h51);
    cyc();
    check("b_hold_valid", b_rd_valid, 0);
    check("b_hold_data", b_rd_data, 8'h51);
    b_rd_en = 1;
    cyc();
    b_rd_en = 0;
    check("b_r2_valid", b_rd_valid, 1);
    check("b_r2_data", b_rd_data, 8'h52);
    cyc();
    check("b_end_valid", b_rd_valid, 0);
    check("b_end_empty", b_empty, 1);

    check("a_queue_left", exp_a.size(), 0);
    check("b_queue_left", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
